// File: rtl/axis_bram_writer.sv
// axis_bram_writer
// ----------------
// AXI-Stream slave that loads one D2Q9 lattice frame into the nine
// per-direction distribution BRAMs. Every accepted beat carries the nine
// 16-bit directions of one pixel. Beats are written to addresses
// 0..DEPTH-1 in arrival order, one cycle after the handshake.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   frame_start        one-cycle pulse, arms reception of one frame (IDLE only)
//   s_tdata            {n, null, ne, e, se, s, sw, w, nw}, n in the top bits
//   s_tvalid, s_tlast  stream valid / last
//   s_tready           stream ready (high in RECV and DRAIN)
//   wr_en, wr_addr     common write strobe and address for all nine BRAMs
//   n .. nw            per-direction write data; holds while wr_en is low
//   busy               frame armed and not yet terminated
//   frame_done         one-cycle pulse when the frame terminates
//   err_early_tlast    sticky: s_tlast before pixel DEPTH-1
//   err_missing_tlast  sticky: pixel DEPTH-1 without s_tlast
//
// Handshake: a beat transfers on a rising clk edge where s_tvalid and
// s_tready are both high; s_tready depends only on the FSM state, never
// on s_tvalid, and the source must hold s_tdata/s_tlast stable while
// s_tvalid is high and s_tready is low.

module axis_bram_writer #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [9*DATA_WIDTH-1:0]  s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    n,
  output logic [DATA_WIDTH-1:0]    null_d,
  output logic [DATA_WIDTH-1:0]    ne,
  output logic [DATA_WIDTH-1:0]    e,
  output logic [DATA_WIDTH-1:0]    se,
  output logic [DATA_WIDTH-1:0]    s,
  output logic [DATA_WIDTH-1:0]    sw,
  output logic [DATA_WIDTH-1:0]    w,
  output logic [DATA_WIDTH-1:0]    nw,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_early_tlast,
  output logic                     err_missing_tlast
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state_q;
  logic [ADDRESS_WIDTH-1:0]   cnt_q;
  logic [ADDRESS_WIDTH-1:0]   cnt_d;
  logic [ADDRESS_WIDTH-1:0]   wr_addr_q;
  logic [9*DATA_WIDTH-1:0]    data_q;
  logic                       tready_q;
  logic                       wr_en_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       err_early_q;
  logic                       err_missing_q;
  logic                       hs;
  logic                       at_last;

  always_comb begin
    hs      = s_tvalid && tready_q;
    at_last = (cnt_q == LAST_ADDR);
    cnt_d   = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_addr_q     <= '0;
      data_q        <= '0;
      tready_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      // Strobes default low; only a handshake or DONE raises them.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q       <= RECV;
            cnt_q         <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            busy_q        <= 1'b1;
            tready_q      <= 1'b1;
          end
        end
        RECV: begin
          if (hs) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            data_q    <= s_tdata;
            if (at_last) begin
              // The counter stays at DEPTH-1 so no later write can
              // ever go beyond the BRAM.
              if (s_tlast) begin
                state_q  <= DONE;
                tready_q <= 1'b0;
              end else begin
                err_missing_q <= 1'b1;
                state_q       <= DRAIN;
              end
            end else begin
              cnt_q <= cnt_d;
              if (s_tlast) begin
                err_early_q <= 1'b1;
                state_q     <= DONE;
                tready_q    <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          // Surplus beats are swallowed until the source closes the packet.
          if (hs && s_tlast) begin
            state_q  <= DONE;
            tready_q <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_tready          = tready_q;
  assign wr_en             = wr_en_q;
  assign wr_addr           = wr_addr_q;
  assign busy              = busy_q;
  assign frame_done        = done_q;
  assign err_early_tlast   = err_early_q;
  assign err_missing_tlast = err_missing_q;

  assign n      = data_q[8*DATA_WIDTH +: DATA_WIDTH];
  assign null_d = data_q[7*DATA_WIDTH +: DATA_WIDTH];
  assign ne     = data_q[6*DATA_WIDTH +: DATA_WIDTH];
  assign e      = data_q[5*DATA_WIDTH +: DATA_WIDTH];
  assign se     = data_q[4*DATA_WIDTH +: DATA_WIDTH];
  assign s      = data_q[3*DATA_WIDTH +: DATA_WIDTH];
  assign sw     = data_q[2*DATA_WIDTH +: DATA_WIDTH];
  assign w      = data_q[1*DATA_WIDTH +: DATA_WIDTH];
  assign nw     = data_q[0*DATA_WIDTH +: DATA_WIDTH];

endmodule
